// File: rtl/i2c_tgt_pkg.sv
// i2c_tgt_pkg: shared types and constants for the I2C target register file.
//   i2c_tgt_state_e    - protocol FSM state encoding (also exported on DBG_STATE_O)
//   I2C_BITS_PER_BYTE  - data bits per byte before the ACK slot
//   I2C_RW_READ        - value of the R/W bit that requests a read
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } i2c_tgt_state_e;

    localparam logic [3:0] I2C_BITS_PER_BYTE = 4'd8;
    localparam logic       I2C_RW_READ       = 1'b1;

endpackage

// File: rtl/i2c_tgt_line_cond.sv
// i2c_tgt_line_cond: conditions one open-drain bus line into the system clock domain.
// A 2-flop synchronizer feeds a registered edge detector. When the macro
// I2C_TGT_GLITCH_FILTER_EN is defined, a 3-sample majority filter sits between
// the synchronizer and the edge detector, suppressing 1-cycle pulses (+2 cycles latency).
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (line assumed idle-high)
//   line  in   raw resolved bus line
//   level out  conditioned line level, aligned with rise/fall
//   rise  out  one-cycle pulse on a 0->1 transition
//   fall  out  one-cycle pulse on a 1->0 transition
module i2c_tgt_line_cond (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, cond, level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= line;
            s2 <= s1;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt_q;

    // A new level must be seen on two of the last three samples to pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist   <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist   <= {hist[0], s2};
            filt_q <= (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
        end
    end
    assign cond = filt_q;
`else
    assign cond = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            level_q <= cond;
            rise    <= cond & ~level_q;
            fall    <= ~cond & level_q;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a DEPTH-entry byte register file.
// Matches TGT_ADDR, ACKs, loads a pointer on the first written byte, stores
// following bytes with pointer auto-increment and serves reads from the pointer.
// Optional macro: I2C_TGT_GLITCH_FILTER_EN (majority filter in the line conditioners).
// Ports:
//   CLK_I         in   system clock (>= 16x SCL)
//   RESET         in   asynchronous active-high reset
//   SCL_PAD_I     in   resolved SCL line
//   SDA_PAD_I     in   resolved SDA line
//   SDA_PAD_O     out  SDA drive value, always 0
//   SDA_PADOEN_O  out  SDA output enable, active-low (0 pulls low, 1 releases)
//   WR_STB_O      out  write strobe
//   WR_ADDR_O     out  register index of the last stored byte
//   WR_DATA_O     out  last stored byte
//   BUSY_O        out  high from an address-matched ACK until STOP or START
//   DBG_STATE_O   out  current FSM state (i2c_tgt_state_e encoding)
// Write report protocol: WR_STB_O is a single-cycle valid with no ready; the
// consumer must accept it in that cycle. WR_ADDR_O/WR_DATA_O are valid while
// WR_STB_O is high and hold their values until the next strobe.
module i2c_target_regfile
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         DEPTH    = 16
) (
    input  logic                     CLK_I,
    input  logic                     RESET,
    input  logic                     SCL_PAD_I,
    input  logic                     SDA_PAD_I,
    output logic                     SDA_PAD_O,
    output logic                     SDA_PADOEN_O,
    output logic                     WR_STB_O,
    output logic [$clog2(DEPTH)-1:0] WR_ADDR_O,
    output logic [7:0]               WR_DATA_O,
    output logic                     BUSY_O,
    output logic [3:0]               DBG_STATE_O
);

    localparam int PW = $clog2(DEPTH);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_evt, stop_evt, mem_we;

    i2c_tgt_state_e state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [PW-1:0]  ptr;
    logic           sda_oen;
    logic [7:0]     mem [DEPTH];
    logic [7:0]     mem_rd;

    i2c_tgt_line_cond u_scl (.clk(CLK_I), .rst(RESET), .line(SCL_PAD_I),
                             .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_tgt_line_cond u_sda (.clk(CLK_I), .rst(RESET), .line(SDA_PAD_I),
                             .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    // Both lines share the same pipeline, so scl_lvl is aligned with the SDA edges.
    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;
    assign mem_rd    = mem[ptr];
    assign mem_we    = !start_evt && !stop_evt && (state == ST_WDATA) &&
                       scl_fall && (bit_cnt == I2C_BITS_PER_BYTE);

    always_ff @(posedge CLK_I or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'd0;
            ptr       <= '0;
            sda_oen   <= 1'b1;
            WR_STB_O  <= 1'b0;
            WR_ADDR_O <= '0;
            WR_DATA_O <= 8'd0;
            BUSY_O    <= 1'b0;
        end else begin
            WR_STB_O <= 1'b0;
            if (start_evt) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oen <= 1'b1;
                BUSY_O  <= 1'b0;
            end else if (stop_evt) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_oen <= 1'b1;
                BUSY_O  <= 1'b0;
            end else begin
                unique case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (scl_rise && bit_cnt != I2C_BITS_PER_BYTE) begin
                            shreg   <= {shreg[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == I2C_BITS_PER_BYTE) begin
                            bit_cnt <= 4'd0;
                            if (state == ST_ADDR) begin
                                if (shreg[7:1] == TGT_ADDR) begin
                                    state   <= ST_ADDR_ACK;
                                    sda_oen <= 1'b0;
                                    BUSY_O  <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else if (state == ST_PTR) begin
                                ptr     <= shreg[PW-1:0];
                                state   <= ST_PTR_ACK;
                                sda_oen <= 1'b0;
                            end else begin
                                WR_STB_O  <= 1'b1;
                                WR_ADDR_O <= ptr;
                                WR_DATA_O <= shreg;
                                ptr       <= ptr + 1'b1;
                                state     <= ST_WDATA_ACK;
                                sda_oen   <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // shreg still holds the address byte, so bit 0 is R/W.
                        if (scl_fall) begin
                            if (shreg[0] == I2C_RW_READ) begin
                                state   <= ST_RDATA;
                                shreg   <= mem_rd;
                                sda_oen <= mem_rd[7];
                            end else begin
                                state   <= ST_PTR;
                                sda_oen <= 1'b1;
                            end
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            state   <= ST_WDATA;
                            sda_oen <= 1'b1;
                        end
                    end
                    ST_RDATA: begin
                        // bit_cnt counts bits already sampled by the master;
                        // 7-bit_cnt is the next bit to present (MSB first).
                        if (scl_rise && bit_cnt != I2C_BITS_PER_BYTE) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == I2C_BITS_PER_BYTE) begin
                                state   <= ST_RDATA_ACK;
                                sda_oen <= 1'b1;
                            end else begin
                                sda_oen <= shreg[~bit_cnt[2:0]];
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        // A NACK leaves on the rise, so any fall seen here follows an ACK.
                        if (scl_rise) begin
                            if (sda_lvl) state <= ST_IGNORE;
                            else         ptr   <= ptr + 1'b1;
                        end else if (scl_fall) begin
                            state   <= ST_RDATA;
                            bit_cnt <= 4'd0;
                            shreg   <= mem_rd;
                            sda_oen <= mem_rd[7];
                        end
                    end
                    default: begin
                        // IDLE and IGNORE wait for START/STOP only.
                    end
                endcase
            end
        end
    end

    // Register storage is deliberately left without reset.
    always_ff @(posedge CLK_I) begin
        if (mem_we) mem[ptr] <= shreg;
    end

    assign SDA_PAD_O    = 1'b0;
    assign SDA_PADOEN_O = sda_oen;
    assign DBG_STATE_O  = state;

endmodule
